// File: rtl/taxi_ram_port_arb.sv
// taxi_ram_port_arb: round-robin arbiter sharing one taxi RAM port between
// PORTS requesters. Commands are registered once before the RAM and read data
// comes back two cycles after the transfer, tagged to the issuing port.
// A per-port lock keeps the grant for atomic multi-beat sequences.
// Optional feature macro TAXI_RAM_ARB_INIT_EN: zero-fill the whole RAM after
// reset before accepting any command.
module taxi_ram_port_arb #(
  parameter int PORTS  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         req_valid,
  output logic [PORTS-1:0]         req_ready,
  input  logic [PORTS-1:0]         req_lock,
  input  logic [PORTS*ADDR_W-1:0]  req_addr,
  input  logic [PORTS-1:0]         req_wr_en,
  input  logic [PORTS*DATA_W-1:0]  req_wr_data,
  input  logic [PORTS*STRB_W-1:0]  req_wr_strb,
  output logic [PORTS-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     ram_en,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_wr_en,
  output logic [DATA_W-1:0]        ram_wr_data,
  output logic [STRB_W-1:0]        ram_wr_strb,
  input  logic [DATA_W-1:0]        ram_rd_data,
  output logic                     init_done
);

  localparam int ID_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  if ((DATA_W % STRB_W) != 0) begin : g_strb_chk
    $fatal(1, "taxi_ram_port_arb: DATA_W must be divisible by STRB_W");
  end

  // Read-tracking tag carried alongside the RAM access.
  typedef struct packed {
    logic            rd;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   lock_id;
  logic              lock_vld;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   scan_id;
  logic              gnt_hit;
  rd_tag_t           tag_s1;
  rd_tag_t           tag_s2;
  logic              init_wr;
  logic [ADDR_W-1:0] init_addr;

  // Grant selection: live lock owner first, else first valid port from ptr.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    gnt_hit = 1'b0;
    gnt_id  = '0;
    scan_id = '0;
    if (init_done) begin
      if (lock_vld && req_valid[lock_id]) begin
        gnt_hit = 1'b1;
        gnt_id  = lock_id;
      end else begin
        for (int i = 0; i < PORTS; i++) begin
          scan_id = ID_W'((int'(ptr) + i) % PORTS);
          if (!gnt_hit && req_valid[scan_id]) begin
            gnt_hit = 1'b1;
            gnt_id  = scan_id;
          end
        end
      end
    end
  end

  // One-hot ready for the granted port only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < PORTS; i++) begin
      req_ready[i] = gnt_hit && (gnt_id == ID_W'(i));
    end
  end

  // Priority pointer and lock owner follow each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so all registers update together at the edge.
      ptr      <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
    end else if (gnt_hit) begin
      if (req_lock[gnt_id]) begin
        lock_vld <= 1'b1;
        lock_id  <= gnt_id;
      end else begin
        lock_vld <= 1'b0;
        ptr      <= (gnt_id == ID_W'(PORTS - 1)) ? '0 : gnt_id + 1'b1;
      end
    end else begin
      // No transfer means any lock owner has dropped valid.
      lock_vld <= 1'b0;
    end
  end

  // Command register in front of the RAM; payload holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en      <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      ram_wr_strb <= '0;
    end else if (init_wr) begin
      ram_en      <= 1'b1;
      ram_wr_en   <= 1'b1;
      ram_addr    <= init_addr;
      ram_wr_data <= '0;
      ram_wr_strb <= '1;
    end else if (gnt_hit) begin
      ram_en      <= 1'b1;
      ram_wr_en   <= req_wr_en[gnt_id];
      ram_addr    <= req_addr[gnt_id*ADDR_W +: ADDR_W];
      ram_wr_data <= req_wr_data[gnt_id*DATA_W +: DATA_W];
      ram_wr_strb <= req_wr_strb[gnt_id*STRB_W +: STRB_W];
    end else begin
      ram_en    <= 1'b0;
      ram_wr_en <= 1'b0;
    end
  end

  // Two-stage read tag pipeline matching command register plus RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1.rd <= gnt_hit && !req_wr_en[gnt_id];
      tag_s1.id <= gnt_id;
      tag_s2    <= tag_s1;
    end
  end

  // Response strobe to the tagged port, RAM data passed straight through.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_s2.rd) begin
      rsp_valid[tag_s2.id] = 1'b1;
      rsp_data             = ram_rd_data;
    end
  end

`ifdef TAXI_RAM_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;

  // State register and fill address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (init_wr) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Leave INIT once the last address has been written.
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_cnt == '1) state_nxt = ST_RUN;
  end

  // Fill writes while in INIT; arbitration only in RUN.
  always_comb begin
    init_wr   = (state == ST_INIT);
    init_done = (state == ST_RUN);
    init_addr = init_cnt;
  end
`else
  // Start arbitrating on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

endmodule
